axi_rd_seq: RTL
===============

# axi_rd_seq

Transfer sequencer in front of the single-burst AXI read engine. It accepts one read command (start address, byte length) and splits it into bursts of at most MAX_BURST_BYTES that never cross a MAX_BURST_BYTES-aligned boundary, and therefore never cross a 4 KB boundary. It issues the bursts one at a time, counts returned data beats to detect completion, and pulses `done` once the whole command has been delivered.

## Interface
- AXI_DATA_WIDTH, 32, data width of the read engine; BPB = AXI_DATA_WIDTH/8 bytes per beat
- AXI_ADDR_WIDTH, 16, address width
- LEN_WIDTH, 20, width of command and burst byte lengths
- MAX_BURST_BYTES, 256, maximum bytes per burst; power of two, ≥ BPB, ≤ 4096, ≤ 256·BPB
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept; a command is taken on cmd_valid && cmd_ready
- cmd_addr  in  AXI_ADDR_WIDTH  start byte address
- cmd_len  in  LEN_WIDTH  total bytes
- rd_req  out  1  burst request to the read engine
- rd_req_ready  in  1  engine accepts; a burst is issued on rd_req && rd_req_ready
- rd_addr  out  AXI_ADDR_WIDTH  burst start address
- rd_burst_len  out  LEN_WIDTH  burst length in bytes, a multiple of BPB
- rd_data_valid  in  1  one data beat returned by the engine
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse when the command completes

## Operation
- States: IDLE, ISSUE, WAIT, DONE. An illegal state returns to IDLE.
- **IDLE**
  - cmd_ready = 1.
  - On accept: cur_addr = cmd_addr with the low log2(BPB) bits cleared; remaining = cmd_len rounded up to a multiple of BPB.
  - Go to DONE if remaining = 0, otherwise go to ISSUE.
- **Chunk size**
  - chunk = min(remaining, MAX_BURST_BYTES − cur_addr[log2(MAX_BURST_BYTES)−1:0]).
  - The comparison is done at LEN_WIDTH+1 bits.
- **ISSUE**
  - rd_req = 1, with rd_addr = cur_addr and rd_burst_len = chunk, all registered.
  - These three outputs stay stable until rd_req_ready is seen.
  - On handshake: beats_left = chunk/BPB (counter width log2(MAX_BURST_BYTES/BPB)+1), cur_addr += chunk (wraps modulo 2^AXI_ADDR_WIDTH), remaining −= chunk.
  - rd_req is 0 from the next cycle, and the state goes to WAIT.
- **WAIT**
  - Each rd_data_valid decrements beats_left.
  - When the final beat arrives (beats_left = 1 with rd_data_valid): go to DONE if remaining = 0, otherwise go to ISSUE.
- **DONE**
  - done = 1 for exactly one cycle, then return to IDLE.
  - cmd_ready = 0 in this state.
- rd_data_valid outside WAIT is ignored and has no effect on the counters.
- Only one burst is ever outstanding.
- cmd_valid while the block is busy is not accepted, and its fields are not sampled.

## Timing
- **Reset values:** rd_req 0, rd_addr 0, rd_burst_len 0, busy 0, done 0, state IDLE. cmd_ready is 0 while rst is high and 1 on the first cycle after rst falls.
- **Command accept → first request:** command accepted at edge T; rd_req is high during cycle T+1.
- **Handshake → WAIT:** handshake at edge H; rd_req is low and the state is WAIT during cycle H+1.
- **Back-to-back bursts:** last beat of a burst sampled at edge E; the next rd_req is high during cycle E+1 (one-cycle gap).
- **Command completion:** last beat of the final burst at edge E; done is high during cycle E+1, and cmd_ready is high from cycle E+2.
- **Zero-length command:** accept at T; done is high during cycle T+1, and no rd_req is issued.
- **Same-edge handshake and beat:** rd_req_ready and rd_data_valid both high in the ISSUE cycle. The handshake is taken and the beat is ignored (the engine cannot return data before the request).
- **Reset mid-operation:** abandons the command, drops rd_req the next cycle, emits no done, and clears all counters.
- **Address wrap:** cur_addr at 2^AXI_ADDR_WIDTH wraps to 0. Because every boundary is MAX-aligned, a burst never spans the wrap.

## Test plan
- **Aligned multi-burst** (defaults): addr 0x0000, len 1024 → bursts (0x0000, 256), (0x0100, 256), (0x0200, 256), (0x0300, 256), each closed by 64 beats; exactly one done pulse, one cycle after beat 256.
- **Unaligned start:** addr 0x00F0, len 0x120 → (0x00F0, 16), (0x0100, 256), (0x0200, 16); done after 72 total beats.
- **Backpressure:** rd_req_ready held low for 10 cycles in ISSUE → rd_req, rd_addr and rd_burst_len are unchanged throughout; beats injected during this time are ignored and the state stays ISSUE.
- **Zero length and rounding:**
  - len 0 → done in the cycle after accept, no rd_req.
  - addr 0x0013, len 5 → single burst (0x0010, 8).
- **Wrap:** addr 0xFFC0, len 0x80 → (0xFFC0, 64), (0x0000, 64), done once.
- **Reset mid-burst:** rst after 10 of 64 beats → rd_req 0, busy 0, no done; cmd_ready 1 after release; a new command addr 0x0200, len 8 then completes normally.

Source files
------------

// File: rtl/axi_rd_seq_if.sv
// rtl/axi_rd_seq_if.sv - command and read-engine handshake bundle for axi_rd_seq
interface axi_rd_seq_if #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int LEN_WIDTH      = 20
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]      cmd_len;
    logic                      rd_req;
    logic                      rd_req_ready;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr;
    logic [LEN_WIDTH-1:0]      rd_burst_len;
    logic                      rd_data_valid;
    logic                      busy;
    logic                      done;

    // Command issuer plus read engine side.
    modport master (
        output cmd_valid, cmd_addr, cmd_len, rd_req_ready, rd_data_valid,
        input  cmd_ready, rd_req, rd_addr, rd_burst_len, busy, done
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, rd_req_ready, rd_data_valid,
        output cmd_ready, rd_req, rd_addr, rd_burst_len, busy, done
    );
endinterface

// File: rtl/axi_rd_seq.sv
// rtl/axi_rd_seq.sv - splits a read command into boundary-safe bursts, one outstanding at a time
module axi_rd_seq #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 20,
    parameter int MAX_BURST_BYTES = 256
) (
    input  logic         clk,
    input  logic         rst,
    axi_rd_seq_if.slave  bus
);
    localparam int BPB    = AXI_DATA_WIDTH / 8;
    localparam int BPB_LG = $clog2(BPB);
    localparam int MAX_LG = $clog2(MAX_BURST_BYTES);
    localparam int BEAT_W = $clog2(MAX_BURST_BYTES / BPB) + 1;
    // One extra bit so a length rounded up past 2^LEN_WIDTH-1 does not overflow.
    localparam int RW     = LEN_WIDTH + 1;

    localparam logic [RW-1:0]             BPB_MASK  = RW'(BPB - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = AXI_ADDR_WIDTH'(BPB - 1);
    localparam logic [RW-1:0]             MAX_BYTES = RW'(MAX_BURST_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [RW-1:0]             remaining_q, remaining_d;
    logic [BEAT_W-1:0]         beats_left_q, beats_left_d;
    logic                      rd_req_q;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr_q;
    logic [LEN_WIDTH-1:0]      rd_len_q;

    logic                      cmd_ready_w;
    logic [RW-1:0]             len_round;
    logic [RW-1:0]             room;
    logic [RW-1:0]             chunk_d;
    logic                      enter_issue;

    assign cmd_ready_w = (state_q == S_IDLE) && !rst;
    assign len_round   = ({1'b0, bus.cmd_len} + BPB_MASK) & ~BPB_MASK;

    // Next-state and datapath updates; defaults hold every register.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        beats_left_d = beats_left_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_w) begin
                    cur_addr_d  = bus.cmd_addr & ~ADDR_MASK;
                    remaining_d = len_round;
                    state_d     = (len_round == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Beats seen here are dropped: nothing is outstanding yet.
                if (bus.rd_req_ready) begin
                    beats_left_d = BEAT_W'(rd_len_q >> BPB_LG);
                    cur_addr_d   = cur_addr_q + AXI_ADDR_WIDTH'(rd_len_q);
                    remaining_d  = remaining_q - RW'(rd_len_q);
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.rd_data_valid) begin
                    beats_left_d = beats_left_q - BEAT_W'(1);
                    if (beats_left_q == BEAT_W'(1)) begin
                        state_d = (remaining_q == '0) ? S_DONE : S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Burst size for the request about to be loaded: limited by what is left
    // and by the distance to the next MAX-aligned boundary.
    assign room        = MAX_BYTES - RW'(cur_addr_d[MAX_LG-1:0]);
    assign chunk_d     = (remaining_d < room) ? remaining_d : room;
    assign enter_issue = (state_d == S_ISSUE) && (state_q != S_ISSUE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters and registered request outputs; request fields freeze until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            beats_left_q <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            rd_len_q     <= '0;
        end else begin
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            beats_left_q <= beats_left_d;
            if (enter_issue) begin
                rd_req_q  <= 1'b1;
                rd_addr_q <= cur_addr_d;
                rd_len_q  <= LEN_WIDTH'(chunk_d);
            end else if ((state_q == S_ISSUE) && bus.rd_req_ready) begin
                rd_req_q  <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready    = cmd_ready_w;
    assign bus.rd_req       = rd_req_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.rd_burst_len = rd_len_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);

endmodule
